// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: state codes, decode keys,
// ALUOp encodings and the instruction class type.
package multicycle_control_pkg;

   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_EXEC_R = 4'd2;
   localparam logic [3:0] ST_ADDR   = 4'd3;
   localparam logic [3:0] ST_MEM_RD = 4'd4;
   localparam logic [3:0] ST_MEM_WR = 4'd5;
   localparam logic [3:0] ST_WB_R   = 4'd6;
   localparam logic [3:0] ST_WB_LD  = 4'd7;
   localparam logic [3:0] ST_CBZ    = 4'd8;
   localparam logic [3:0] ST_B      = 4'd9;
   localparam logic [3:0] ST_FAULT  = 4'd10;

   // Key is {opCode[10], opCode[6], opCode[4], opCode[1]}
   localparam logic [1:0] KEY_B_PFX   = 2'b00;
   localparam logic [1:0] KEY_CBZ_PFX = 2'b10;
   localparam logic [3:0] KEY_LDUR    = 4'b1101;
   localparam logic [3:0] KEY_STUR    = 4'b1100;
   localparam logic [3:0] KEY_RTYPE   = 4'b1110;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   typedef enum logic [2:0] {
      ClsB,
      ClsCbz,
      ClsLdur,
      ClsStur,
      ClsRType,
      ClsIllegal
   } instrClass_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps the 4-bit opcode key onto an instruction class.
module instr_class_decode
   import multicycle_control_pkg::*;
(
   input  logic [3:0]  key,
   output instrClass_t instrClass
);

   always_comb begin
      instrClass = ClsIllegal;
      if (key[3:2] == KEY_B_PFX) begin
         instrClass = ClsB;
      end else if (key[3:2] == KEY_CBZ_PFX) begin
         instrClass = ClsCbz;
      end else if (key == KEY_LDUR) begin
         instrClass = ClsLdur;
      end else if (key == KEY_STUR) begin
         instrClass = ClsStur;
      end else if (key == KEY_RTYPE) begin
         instrClass = ClsRType;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller FSM with memory wait timeout and retired-instruction counter.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      opCode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             InstrRead,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             Reg2Loc,
   output logic             ALUSrc,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [1:0]       ALUOp,
   output logic [CNT_W-1:0] retired,
   output logic             fault
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [3:0]        stateQ, stateD;
   logic [WAIT_W-1:0] waitQ, waitD;
   logic [CNT_W-1:0]  retiredQ, retiredD;
   logic              runQ;
   logic [3:0]        key;
   instrClass_t       instrClass;
   logic              waiting, timeout, retire;
   logic              unusedOpBits;

   assign key          = {opCode[10], opCode[6], opCode[4], opCode[1]};
   assign unusedOpBits = ^{opCode[9:7], opCode[5], opCode[3:2], opCode[0]};

   instr_class_decode uDecode (
      .key        (key),
      .instrClass (instrClass)
   );

   // runQ holds everything idle until the first edge after reset is released
   assign waiting = runQ && (stateQ == ST_FETCH || stateQ == ST_MEM_RD || stateQ == ST_MEM_WR);
   assign timeout = waiting && !mem_ready && (waitQ == WAIT_W'(MEM_TIMEOUT - 1));
   assign retire  = runQ && (stateQ == ST_WB_R || stateQ == ST_WB_LD || stateQ == ST_CBZ ||
                             stateQ == ST_B || (stateQ == ST_MEM_WR && mem_ready));

   always_comb begin
      stateD = stateQ;
      if (runQ) begin
         case (stateQ)
            ST_FETCH: begin
               if (mem_ready)    stateD = ST_DECODE;
               else if (timeout) stateD = ST_FAULT;
            end
            ST_DECODE: begin
               case (instrClass)
                  ClsRType:         stateD = ST_EXEC_R;
                  ClsLdur, ClsStur: stateD = ST_ADDR;
                  ClsCbz:           stateD = ST_CBZ;
                  ClsB:             stateD = ST_B;
                  default:          stateD = ST_FAULT;
               endcase
            end
            ST_EXEC_R: stateD = ST_WB_R;
            ST_ADDR:   stateD = (instrClass == ClsStur) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
               if (mem_ready)    stateD = ST_WB_LD;
               else if (timeout) stateD = ST_FAULT;
            end
            ST_MEM_WR: begin
               if (mem_ready)    stateD = ST_FETCH;
               else if (timeout) stateD = ST_FAULT;
            end
            ST_WB_R, ST_WB_LD, ST_CBZ, ST_B: stateD = ST_FETCH;
            default: stateD = ST_FAULT;
         endcase
      end
   end

   always_comb begin
      waitD = waitQ;
      if (stateD != stateQ)           waitD = '0;
      else if (waiting && !mem_ready) waitD = waitQ + 1'b1;
   end

   assign retiredD = retire ? retiredQ + CNT_W'(1) : retiredQ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ   <= ST_FETCH;
         waitQ    <= '0;
         retiredQ <= '0;
         runQ     <= 1'b0;
      end else begin
         stateQ   <= stateD;
         waitQ    <= waitD;
         retiredQ <= retiredD;
         runQ     <= 1'b1;
      end
   end

   assign retired = retiredQ;

   always_comb begin
      InstrRead = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      Reg2Loc   = 1'b0;
      ALUSrc    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ALUOp     = ALUOP_ADD;
      fault     = 1'b0;
      if (runQ) begin
         case (stateQ)
            ST_FETCH: begin
               InstrRead = 1'b1;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            ST_EXEC_R: ALUOp = ALUOP_RTYPE;
            ST_ADDR: begin
               ALUSrc  = 1'b1;
               Reg2Loc = (instrClass == ClsStur);
            end
            ST_MEM_RD: begin
               MemRead = 1'b1;
               ALUSrc  = 1'b1;
            end
            ST_MEM_WR: begin
               MemWrite = 1'b1;
               ALUSrc   = 1'b1;
            end
            ST_WB_R:  RegWrite = 1'b1;
            ST_WB_LD: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            ST_CBZ: begin
               Reg2Loc = 1'b1;
               ALUOp   = ALUOP_PASSB;
               PCWrite = zero;
               PCSrc   = zero;
            end
            ST_B: begin
               PCWrite = 1'b1;
               PCSrc   = 1'b1;
            end
            ST_FAULT: fault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_B    = 11'b00010100000;
   localparam logic [10:0] OP_ILL  = 11'b10001010010;

   // ctl = {InstrRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg,
   //        RegWrite, MemRead, MemWrite, ALUOp[1:0], fault}
   localparam logic [12:0] C_IDLE    = 13'h0000;
   localparam logic [12:0] C_FWAIT   = 13'h1000;
   localparam logic [12:0] C_FRDY    = 13'h1C00;
   localparam logic [12:0] C_EXEC    = 13'h0004;
   localparam logic [12:0] C_WBR     = 13'h0020;
   localparam logic [12:0] C_ADDR_LD = 13'h0080;
   localparam logic [12:0] C_ADDR_ST = 13'h0180;
   localparam logic [12:0] C_MRD     = 13'h0090;
   localparam logic [12:0] C_MWR     = 13'h0088;
   localparam logic [12:0] C_WBLD    = 13'h0060;
   localparam logic [12:0] C_CBZ_T   = 13'h0702;
   localparam logic [12:0] C_CBZ_N   = 13'h0102;
   localparam logic [12:0] C_B       = 13'h0600;
   localparam logic [12:0] C_FAULT   = 13'h0001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] opCode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        InstrRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc;
   logic        MemtoReg, RegWrite, MemRead, MemWrite, fault;
   logic [1:0]  ALUOp;
   logic [3:0]  retired;
   wire  [12:0] ctl = {InstrRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg,
                       RegWrite, MemRead, MemWrite, ALUOp, fault};

   int checks = 0;
   int failures = 0;

   multicycle_control #(
      .MEM_TIMEOUT (16),
      .CNT_W       (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .opCode    (opCode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .InstrRead (InstrRead),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .PCSrc     (PCSrc),
      .Reg2Loc   (Reg2Loc),
      .ALUSrc    (ALUSrc),
      .MemtoReg  (MemtoReg),
      .RegWrite  (RegWrite),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .ALUOp     (ALUOp),
      .retired   (retired),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      mem_ready = 1'b0;
      zero = 1'b0;
      #2;
      @(negedge clk);
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      #3;
      checks++;
      if (ctl !== C_IDLE) begin
         failures++;
         $display("FAIL reset_ctl: got %h expected %h", ctl, C_IDLE);
      end
      checks++;
      if (retired !== 4'd0) begin
         failures++;
         $display("FAIL reset_retired: got %0d expected 0", retired);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin
         failures++;
         $display("FAIL reset_before_edge: got %h expected %h", ctl, C_IDLE);
      end
      cyc();
      checks++;
      if (ctl !== C_FWAIT) begin
         failures++;
         $display("FAIL reset_first_fetch: got %h expected %h", ctl, C_FWAIT);
      end
   endtask

   task automatic test_rtype();
      logic [12:0] exp [5] = '{C_FRDY, C_IDLE, C_EXEC, C_WBR, C_FRDY};
      doReset();
      opCode = OP_ADD;
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'b1;
         #1;
         checks++;
         if (ctl !== exp[i]) begin
            failures++;
            $display("FAIL rtype_cyc%0d: got %h expected %h", i, ctl, exp[i]);
         end
         if (i < 4) cyc();
      end
      checks++;
      if (retired !== 4'd1) begin
         failures++;
         $display("FAIL rtype_retired: got %0d expected 1", retired);
      end
   endtask

   task automatic test_ldur();
      logic [12:0] exp [9] = '{C_FRDY, C_IDLE, C_ADDR_LD, C_MRD, C_MRD, C_MRD, C_MRD,
                               C_WBLD, C_FRDY};
      logic        rdy [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      doReset();
      opCode = OP_LDUR;
      for (int i = 0; i < 9; i++) begin
         mem_ready = rdy[i];
         #1;
         checks++;
         if (ctl !== exp[i]) begin
            failures++;
            $display("FAIL ldur_cyc%0d: got %h expected %h", i, ctl, exp[i]);
         end
         if (i < 8) cyc();
      end
      checks++;
      if (retired !== 4'd1) begin
         failures++;
         $display("FAIL ldur_retired: got %0d expected 1", retired);
      end
   endtask

   task automatic test_cbz();
      logic [12:0] exp [7] = '{C_FRDY, C_IDLE, C_CBZ_T, C_FRDY, C_IDLE, C_CBZ_N, C_FRDY};
      logic        zv  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      doReset();
      opCode = OP_CBZ;
      for (int i = 0; i < 7; i++) begin
         mem_ready = 1'b1;
         zero = zv[i];
         #1;
         checks++;
         if (ctl !== exp[i]) begin
            failures++;
            $display("FAIL cbz_cyc%0d: got %h expected %h", i, ctl, exp[i]);
         end
         if (i == 3 || i == 6) begin
            checks++;
            if (retired !== ((i == 3) ? 4'd1 : 4'd2)) begin
               failures++;
               $display("FAIL cbz_retired_cyc%0d: got %0d expected %0d", i, retired,
                        (i == 3) ? 1 : 2);
            end
         end
         if (i < 6) cyc();
      end
   endtask

   task automatic test_stur_timeout();
      logic [12:0] exp;
      doReset();
      opCode = OP_STUR;
      for (int i = 0; i < 21; i++) begin
         mem_ready = (i == 0 || i == 20);
         if (i == 0)      exp = C_FRDY;
         else if (i == 1) exp = C_IDLE;
         else if (i == 2) exp = C_ADDR_ST;
         else if (i < 19) exp = C_MWR;
         else             exp = C_FAULT;
         #1;
         checks++;
         if (ctl !== exp) begin
            failures++;
            $display("FAIL stur_timeout_cyc%0d: got %h expected %h", i, ctl, exp);
         end
         if (i < 20) cyc();
      end
      checks++;
      if (retired !== 4'd0) begin
         failures++;
         $display("FAIL stur_timeout_retired: got %0d expected 0", retired);
      end
   endtask

   task automatic test_illegal();
      logic [12:0] exp;
      doReset();
      opCode = OP_ILL;
      zero = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mem_ready = (i == 0) ? 1'b1 : i[0];
         exp = (i == 0) ? C_FRDY : (i == 1) ? C_IDLE : C_FAULT;
         #1;
         checks++;
         if (ctl !== exp) begin
            failures++;
            $display("FAIL illegal_cyc%0d: got %h expected %h", i, ctl, exp);
         end
         if (i < 7) cyc();
      end
   endtask

   // Fetch waits must not carry into the memory wait; 15 waits still complete.
   task automatic test_wait_clear();
      logic [12:0] exp;
      doReset();
      opCode = OP_STUR;
      for (int i = 0; i < 30; i++) begin
         mem_ready = (i == 10 || i == 28);
         if (i < 10)       exp = C_FWAIT;
         else if (i == 10) exp = C_FRDY;
         else if (i == 11) exp = C_IDLE;
         else if (i == 12) exp = C_ADDR_ST;
         else if (i < 29)  exp = C_MWR;
         else              exp = C_FWAIT;
         #1;
         checks++;
         if (ctl !== exp) begin
            failures++;
            $display("FAIL wait_clear_cyc%0d: got %h expected %h", i, ctl, exp);
         end
         if (i < 29) cyc();
      end
      checks++;
      if (retired !== 4'd1) begin
         failures++;
         $display("FAIL wait_clear_retired: got %0d expected 1", retired);
      end
   endtask

   task automatic test_reset_midwrite();
      doReset();
      opCode = OP_ADD;
      mem_ready = 1'b1;
      repeat (4) cyc();
      opCode = OP_STUR;
      cyc();
      mem_ready = 1'b0;
      cyc();
      cyc();
      #1;
      checks++;
      if (ctl !== C_MWR || retired !== 4'd1) begin
         failures++;
         $display("FAIL midwrite_pre: got %h/%0d expected %h/1", ctl, retired, C_MWR);
      end
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin
         failures++;
         $display("FAIL midwrite_async_ctl: got %h expected %h", ctl, C_IDLE);
      end
      checks++;
      if (retired !== 4'd0) begin
         failures++;
         $display("FAIL midwrite_async_retired: got %0d expected 0", retired);
      end
      @(negedge clk);
      reset = 1'b0;
      cyc();
      checks++;
      if (ctl !== C_FWAIT) begin
         failures++;
         $display("FAIL midwrite_resume: got %h expected %h", ctl, C_FWAIT);
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if (ctl !== C_FRDY) begin
         failures++;
         $display("FAIL midwrite_resume_rdy: got %h expected %h", ctl, C_FRDY);
      end
   endtask

   task automatic test_back_to_back_wrap();
      logic [3:0] expRet = 4'd0;
      doReset();
      opCode = OP_B;
      mem_ready = 1'b1;
      for (int n = 0; n < 17; n++) begin
         #1;
         checks++;
         if (ctl !== C_FRDY) begin
            failures++;
            $display("FAIL b_fetch_%0d: got %h expected %h", n, ctl, C_FRDY);
         end
         cyc();
         cyc();
         checks++;
         if (ctl !== C_B) begin
            failures++;
            $display("FAIL b_branch_%0d: got %h expected %h", n, ctl, C_B);
         end
         cyc();
         expRet = expRet + 4'd1;
         checks++;
         if (retired !== expRet) begin
            failures++;
            $display("FAIL b_retired_%0d: got %0d expected %0d", n, retired, expRet);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_ldur();
      test_cbz();
      test_stur_timeout();
      test_illegal();
      test_wait_clear();
      test_reset_midwrite();
      test_back_to_back_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The parameter list SHALL be: MEM_TIMEOUT, 16, maximum wait cycles for mem_ready before the block enters FAULT.
REQ-002 The parameter list SHALL also include CNT_W, 32, width of the retired-instruction counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opCode  in  11  instruction bits [31:21] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access done; sampled while an access is pending
- InstrRead  out  1  instruction fetch request
- IRWrite  out  1  load instruction register
- PCWrite  out  1  update PC
- PCSrc  out  1  1 selects branch target, 0 selects PC+4
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 pass-B/zero test, 10 R-type funct
- retired  out  CNT_W  count of completed instructions
- fault  out  1  sticky illegal-opcode or timeout flag

Function
REQ-005 Decode SHALL use the key {opCode[10],opCode[6],opCode[4],opCode[1]}: 00xx B; 10xx CBZ; 1101 LDUR; 1100 STUR; 1110 R-type; any other key is illegal.
REQ-006 FSM states SHALL be FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_LD, CBZ, B, FAULT.
REQ-007 FETCH SHALL assert InstrRead and hold it until mem_ready=1; in that cycle it SHALL assert IRWrite and PCWrite with PCSrc=0, then go to DECODE.
REQ-008 DECODE SHALL last one cycle and go to EXEC_R (R-type), ADDR (LDUR/STUR), CBZ, B, or FAULT (illegal).
REQ-009 EXEC_R SHALL drive Reg2Loc=0, ALUSrc=0, ALUOp=10, then go to WB_R; WB_R SHALL assert RegWrite with MemtoReg=0, then go to FETCH.
REQ-010 ADDR SHALL drive ALUSrc=1, ALUOp=00, and Reg2Loc=1 for STUR; it SHALL go to MEM_RD for LDUR or MEM_WR for STUR.
REQ-011 MEM_RD/MEM_WR SHALL hold MemRead/MemWrite with ALUSrc=1 until mem_ready=1, then go to WB_LD (load) or FETCH (store).
REQ-012 WB_LD SHALL assert RegWrite with MemtoReg=1, then go to FETCH.
REQ-013 CBZ SHALL drive Reg2Loc=1, ALUSrc=0, ALUOp=01; if zero=1 it SHALL assert PCWrite with PCSrc=1; it SHALL then go to FETCH.
REQ-014 B SHALL assert PCWrite with PCSrc=1, then go to FETCH.
REQ-015 Every output not named for a state SHALL be 0 in that state; write strobes (RegWrite, MemWrite, PCWrite, IRWrite) SHALL be exactly one cycle except MemWrite, which is held through the wait.
REQ-016 A wait counter SHALL count cycles in FETCH, MEM_RD and MEM_WR while mem_ready=0; reaching MEM_TIMEOUT SHALL go to FAULT; it SHALL clear on every state change.
REQ-017 mem_ready=1 on the first cycle of a wait state SHALL complete the access with no wait cycles.
REQ-018 mem_ready outside FETCH, MEM_RD and MEM_WR SHALL be ignored.
REQ-019 retired SHALL increment by 1 on the last cycle of each instruction (WB_R, WB_LD, MEM_WR completion, CBZ, B); it SHALL wrap to 0 at overflow.
REQ-020 FAULT SHALL set fault=1, hold all strobes at 0, and stay in FAULT until reset.
REQ-021 Outputs SHALL be Moore-decoded from state, except the mem_ready- and zero-qualified strobes.

Reset
REQ-022 Asserting reset SHALL immediately, asynchronously, force state=FETCH, wait counter=0, retired=0, fault=0, and all strobes to 0, including during a pending memory access.
REQ-023 InstrRead SHALL assert on the first rising clk edge after reset deasserts.

Structure
REQ-024 A shared package SHALL hold the state enumeration, the decode-key constants, and the ALUOp encodings.
REQ-025 The key-to-class decoder SHALL be one sub-module, instr_class_decode; the FSM, wait counter and retired counter SHALL stay in multicycle_control.

Verification
REQ-026 The bench SHALL cover these scenarios:
- R-type opCode 11'b10001011000 (ADD), mem_ready=1 on the first cycle -> FETCH, DECODE, EXEC_R, WB_R; RegWrite for one cycle; retired=1.
- LDUR 11'b11111000010 with mem_ready delayed 3 cycles in MEM_RD -> MemRead high for 4 cycles, then WB_LD with MemtoReg=1; total 8 cycles.
- CBZ 11'b10110100xxx with zero=1, then repeated with zero=0 -> PCWrite+PCSrc=1 only in the zero=1 run; retired increments both times.
- STUR with mem_ready stuck at 0 and MEM_TIMEOUT=16 -> FAULT after 16 wait cycles; fault=1; MemWrite drops.
- Illegal key 4'b1111 -> DECODE goes to FAULT; no write strobe ever asserts.
- reset asserted mid-MEM_WR -> outputs go to 0 without a clock edge; FETCH resumes after release.
